// File: rtl/tail_light_seq.sv
// ---------------------------------------------------------------------------
// tail_light_seq
//
// Next-state and timing engine for the tail-light controller. The two mode
// switches are synchronized, the board clock is divided down to a blink-step
// rate, and a four-state sequencer (IDLE, HAZARDS, TURN_LEFT, TURN_RIGHT)
// with a 2-bit phase is advanced once per blink step. The downstream output
// logic decodes CurrentState/phase into the lamp and display drives.
//
// Parameters:
//   TICK_DIV      clock cycles per blink step, legal range 2..2^24
//
// Ports:
//   clk           system clock, all registers update on the rising edge
//   reset         synchronous, active-high reset
//   SW[1:0]       asynchronous mode switches
//                 00 = idle, 01 = left, 10 = right, 11 = hazards
//   CurrentState  registered state code (000 idle, 001 hazards,
//                 010 turn left, 011 turn right)
//   phase         registered sequence position within the state
//   step          one-cycle pulse in the cycle after each tick edge
// ---------------------------------------------------------------------------
module tail_light_seq #(
    parameter int TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    output logic [2:0] CurrentState,
    output logic [1:0] phase,
    output logic       step
);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        HAZARDS    = 3'b001,
        TURN_LEFT  = 3'b010,
        TURN_RIGHT = 3'b011
    } state_t;

    localparam logic [1:0]  REQ_IDLE    = 2'b00;
    localparam logic [1:0]  REQ_LEFT    = 2'b01;
    localparam logic [1:0]  REQ_RIGHT   = 2'b10;
    localparam logic [1:0]  REQ_HAZARDS = 2'b11;

    // 24 bits holds every count up to TICK_DIV-1 for TICK_DIV up to 2^24.
    localparam logic [23:0] CNT_LAST    = 24'(TICK_DIV - 1);

    state_t      state;
    logic [1:0]  sw_meta;
    logic [1:0]  req;
    logic [23:0] cnt;
    logic        tick;

    assign tick         = (cnt == CNT_LAST);
    assign CurrentState = state;

    // State entered when leaving IDLE (or a finished sequence) for a
    // requested mode.
    function automatic state_t mode_state(input logic [1:0] r);
        case (r)
            REQ_LEFT:    return TURN_LEFT;
            REQ_RIGHT:   return TURN_RIGHT;
            REQ_HAZARDS: return HAZARDS;
            default:     return IDLE;
        endcase
    endfunction

    // Every active mode starts with its first lit phase; idle stays dark.
    function automatic logic [1:0] mode_phase(input logic [1:0] r);
        return (r == REQ_IDLE) ? 2'd0 : 2'd1;
    endfunction

    // Synchronizer, prescaler, step pulse and sequencer all live in one
    // clocked block so that reset wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= 2'b00;
            req     <= 2'b00;
            cnt     <= '0;
            step    <= 1'b0;
            state   <= IDLE;
            phase   <= 2'd0;
        end else begin
            sw_meta <= SW;
            req     <= sw_meta;
            step    <= tick;
            cnt     <= tick ? 24'd0 : cnt + 24'd1;

            if (tick) begin
                case (state)
                    IDLE: begin
                        state <= mode_state(req);
                        phase <= mode_phase(req);
                    end

                    TURN_LEFT, TURN_RIGHT: begin
                        // Hazards preempt a running turn sequence; otherwise
                        // the sequence always runs through its dark phase 0
                        // before a new mode is picked up.
                        if (req == REQ_HAZARDS) begin
                            state <= HAZARDS;
                            phase <= 2'd1;
                        end else if (phase != 2'd0) begin
                            phase <= phase + 2'd1;
                        end else begin
                            state <= mode_state(req);
                            phase <= mode_phase(req);
                        end
                    end

                    HAZARDS: begin
                        // Leaving hazards from the lit phase first spends one
                        // step dark, so hazards always end with lamps off.
                        if (req == REQ_HAZARDS) begin
                            phase <= (phase == 2'd0) ? 2'd1 : 2'd0;
                        end else if (phase != 2'd0) begin
                            phase <= 2'd0;
                        end else begin
                            state <= mode_state(req);
                            phase <= mode_phase(req);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        phase <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// ---------------------------------------------------------------------------
// tb_tail_light_seq
//
// Self-checking bench for tail_light_seq with TICK_DIV = 4. Each scenario
// task pushes the expected (CurrentState, phase) pair for every upcoming
// step pulse into a scoreboard queue, then pops and compares one entry each
// time the DUT pulses step. Reset scenarios additionally check the exact
// cycle-by-cycle step pattern. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tail_light_seq;

    localparam int TICK_DIV = 4;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_HAZ   = 3'b001;
    localparam logic [2:0] S_LEFT  = 3'b010;
    localparam logic [2:0] S_RIGHT = 3'b011;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] SW;
    logic [2:0] CurrentState;
    logic [1:0] phase;
    logic       step;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    tail_light_seq #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .SW           (SW),
        .CurrentState (CurrentState),
        .phase        (phase),
        .step         (step)
    );

    always #5 clk = ~clk;

    // Global time limit so a stuck DUT can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_exp(input logic [2:0] st, input logic [1:0] ph);
        exp_t e;
        e.st = st;
        e.ph = ph;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge where step is high, bounded.
    task automatic wait_step(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SW    = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (CurrentState !== S_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b, want %b", CurrentState, S_IDLE);
        end
        checks++;
        if (phase !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_phase: got %0d, want 0", phase);
        end
        checks++;
        if (step !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_step: got %b, want 0", step);
        end
        reset = 1'b0;
        // Idle for 40 cycles: step exactly every 4th cycle, state never moves.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (step !== ((k % TICK_DIV) == 0)) begin
                errors++;
                $display("[TB] FAIL idle_step_c%0d: got %b, want %b", k, step, (k % TICK_DIV) == 0);
            end
            checks++;
            if ({CurrentState, phase} !== {S_IDLE, 2'd0}) begin
                errors++;
                $display("[TB] FAIL idle_state_c%0d: got %b/%0d, want 000/0", k, CurrentState, phase);
            end
        end
    endtask

    task automatic test_turn_left();
        exp_t e;
        bit   seen;
        SW = 2'b01;
        push_exp(S_LEFT, 2'd1); push_exp(S_LEFT, 2'd2); push_exp(S_LEFT, 2'd3);
        push_exp(S_LEFT, 2'd0); push_exp(S_LEFT, 2'd1); push_exp(S_LEFT, 2'd2);
        push_exp(S_LEFT, 2'd3); push_exp(S_LEFT, 2'd0); push_exp(S_IDLE, 2'd0);
        for (int i = 0; sb.size() > 0; i++) begin
            wait_step(seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL left_step%0d: no step pulse, want one within %0d cycles", i, 3 * TICK_DIV);
            end else if ({CurrentState, phase} !== {e.st, e.ph}) begin
                errors++;
                $display("[TB] FAIL left_step%0d: got %b/%0d, want %b/%0d", i, CurrentState, phase, e.st, e.ph);
            end
            if (i == 5) SW = 2'b00;
        end
    endtask

    task automatic test_late_change();
        exp_t e;
        bit   seen;
        // A change less than 2 cycles before the tick edge misses that tick.
        repeat (2) @(negedge clk);
        SW = 2'b01;
        push_exp(S_IDLE, 2'd0); push_exp(S_LEFT, 2'd1); push_exp(S_LEFT, 2'd2);
        push_exp(S_LEFT, 2'd3); push_exp(S_LEFT, 2'd0); push_exp(S_IDLE, 2'd0);
        for (int i = 0; sb.size() > 0; i++) begin
            wait_step(seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL late_step%0d: no step pulse, want one within %0d cycles", i, 3 * TICK_DIV);
            end else if ({CurrentState, phase} !== {e.st, e.ph}) begin
                errors++;
                $display("[TB] FAIL late_step%0d: got %b/%0d, want %b/%0d", i, CurrentState, phase, e.st, e.ph);
            end
            if (i == 1) SW = 2'b00;
        end
    endtask

    task automatic test_right_hazards();
        exp_t e;
        bit   seen;
        SW = 2'b10;
        push_exp(S_RIGHT, 2'd1); push_exp(S_HAZ, 2'd1); push_exp(S_HAZ, 2'd0);
        push_exp(S_HAZ, 2'd1);   push_exp(S_HAZ, 2'd0); push_exp(S_HAZ, 2'd1);
        for (int i = 0; sb.size() > 0; i++) begin
            wait_step(seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL haz_step%0d: no step pulse, want one within %0d cycles", i, 3 * TICK_DIV);
            end else if ({CurrentState, phase} !== {e.st, e.ph}) begin
                errors++;
                $display("[TB] FAIL haz_step%0d: got %b/%0d, want %b/%0d", i, CurrentState, phase, e.st, e.ph);
            end
            if (i == 0) SW = 2'b11;
        end
    endtask

    task automatic test_hazard_exit();
        exp_t e;
        bit   seen;
        SW = 2'b01;
        push_exp(S_HAZ, 2'd0); push_exp(S_LEFT, 2'd1);
        for (int i = 0; sb.size() > 0; i++) begin
            wait_step(seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL hazexit_step%0d: no step pulse, want one within %0d cycles", i, 3 * TICK_DIV);
            end else if ({CurrentState, phase} !== {e.st, e.ph}) begin
                errors++;
                $display("[TB] FAIL hazexit_step%0d: got %b/%0d, want %b/%0d", i, CurrentState, phase, e.st, e.ph);
            end
        end
    endtask

    task automatic test_turn_switch();
        exp_t e;
        bit   seen;
        push_exp(S_LEFT, 2'd2);  push_exp(S_LEFT, 2'd3); push_exp(S_LEFT, 2'd0);
        push_exp(S_RIGHT, 2'd1); push_exp(S_RIGHT, 2'd2);
        for (int i = 0; sb.size() > 0; i++) begin
            wait_step(seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL switch_step%0d: no step pulse, want one within %0d cycles", i, 3 * TICK_DIV);
            end else if ({CurrentState, phase} !== {e.st, e.ph}) begin
                errors++;
                $display("[TB] FAIL switch_step%0d: got %b/%0d, want %b/%0d", i, CurrentState, phase, e.st, e.ph);
            end
            if (i == 1) SW = 2'b10;
        end
    endtask

    task automatic test_reset_mid();
        // Entered at the step of TURN_RIGHT phase 2; two more cycles put the
        // prescaler at count 2 before the one-cycle reset.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({CurrentState, phase, step} !== {S_IDLE, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got %b/%0d/%b, want 000/0/0", CurrentState, phase, step);
        end
        for (int k = 1; k <= TICK_DIV; k++) begin
            @(negedge clk);
            checks++;
            if (step !== (k == TICK_DIV)) begin
                errors++;
                $display("[TB] FAIL midreset_step_c%0d: got %b, want %b", k, step, k == TICK_DIV);
            end
            checks++;
            if (k < TICK_DIV && {CurrentState, phase} !== {S_IDLE, 2'd0}) begin
                errors++;
                $display("[TB] FAIL midreset_hold_c%0d: got %b/%0d, want 000/0", k, CurrentState, phase);
            end else if (k == TICK_DIV && {CurrentState, phase} !== {S_RIGHT, 2'd1}) begin
                errors++;
                $display("[TB] FAIL midreset_first: got %b/%0d, want 011/1", CurrentState, phase);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        SW    = 2'b00;
        test_reset();
        test_turn_left();
        test_late_change();
        test_right_hazards();
        test_hazard_exit();
        test_turn_switch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
